score_bcd: RTL and testbench

- Iterative binary-to-BCD converter between the game core's 16-bit score/status number and the 4-digit seven-segment display driver.
- Watches the binary value, reconverts on every change with a shift-and-add-3 (double-dabble) sequence, and holds a stable packed-BCD word for the display.
- Also provides a leading-zero blank mask and an overflow flag for values above the displayable maximum.
- Runs entirely in the main clock domain.

---
 rtl/score_bcd.sv | 131 +++++++++++++
 tb/tb_score_bcd.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd.sv
// score_bcd: iterative binary-to-packed-BCD converter for the score display.
// Watches the binary input and reconverts it whenever it differs from the last
// converted value, or when a refresh pulse arrives. Conversion uses the
// shift-and-add-3 (double-dabble) method, one input bit per clock.
// bcd/blank/ovf are only written in the DONE state, so the display never sees
// a partially converted value.
//
// Handshake: there is no ready. A trigger (bin != last, or refresh) is only
// sampled in IDLE. busy is high from the edge after the trigger until done
// pulses. done is a one-cycle pulse marking the cycle in which the new
// bcd/blank/ovf values first appear. Triggers seen during CONV/DONE are not
// queued; bin is compared against the value actually converted once IDLE is
// reached again.
module score_bcd #(
  parameter int WIDTH   = 16,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bin,
  input  logic             refresh,
  output logic [15:0]      bcd,
  output logic [3:0]       blank,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_last;
  logic [WIDTH-1:0] r_sr;
  logic [15:0]      r_acc;
  logic             r_ovf_next;
  logic [CNT_W-1:0] r_cnt;

  logic             w_trigger;
  logic             w_over;
  logic [WIDTH-1:0] w_clamped;
  logic [15:0]      w_adj;
  logic [3:0]       w_blank;

  // Trigger and clamp decisions; the clamp uses the full input width.
  always_comb begin
    w_trigger = (bin != r_last) || refresh;
    w_over    = (bin > MAX_W);
    w_clamped = w_over ? MAX_W : bin;
  end

  // Add 3 to every accumulator digit >= 5, all digits judged on pre-shift values.
  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < 4; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero mask from the finished accumulator; digit 0 is never blanked.
  always_comb begin
    w_blank    = 4'b0000;
    w_blank[3] = (r_acc[15:12] == 4'd0);
    w_blank[2] = w_blank[3] && (r_acc[11:8] == 4'd0);
    w_blank[1] = w_blank[2] && (r_acc[7:4] == 4'd0);
    w_blank[0] = 1'b0;
  end

  // Conversion FSM with registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last     <= '0;
      r_sr       <= '0;
      r_acc      <= '0;
      r_ovf_next <= 1'b0;
      r_cnt      <= '0;
      bcd        <= 16'h0000;
      blank      <= 4'b1110;
      ovf        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_last     <= bin;
            r_sr       <= w_clamped;
            r_ovf_next <= w_over;
            r_acc      <= '0;
            r_cnt      <= '0;
            busy       <= 1'b1;
            r_state    <= CONV;
          end
        end
        CONV: begin
          {r_acc, r_sr} <= {w_adj, r_sr} << 1;
          r_cnt         <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          bcd     <= r_acc;
          blank   <= w_blank;
          ovf     <= r_ovf_next;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_score_bcd.sv
// tb_score_bcd: self-checking bench for score_bcd.
// Expected display words come from a decimal-arithmetic model of the
// clamp/BCD/blank rules and are queued at stimulus time; a scoreboard pops one
// entry per done pulse. Scenario tasks check timing, counts and reset values.
module tb_score_bcd;

  logic        clk;
  logic        rst;
  logic [15:0] bin;
  logic        refresh;
  logic [15:0] bcd;
  logic [3:0]  blank;
  logic        ovf;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  logic [20:0] exp_q[$];

  score_bcd #(.WIDTH(16), .MAX_VAL(9999)) dut (
    .clk       (clk),
    .rst       (rst),
    .bin       (bin),
    .refresh   (refresh),
    .bcd       (bcd),
    .blank     (blank),
    .ovf       (ovf),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {ovf, blank, bcd} from plain decimal arithmetic.
  function automatic logic [20:0] model(input logic [15:0] v);
    int          c;
    logic        o;
    logic [15:0] b;
    logic [3:0]  bl;
    o  = (v > 16'd9999);
    c  = o ? 9999 : int'(v);
    b  = 16'((c / 1000) * 4096 + ((c / 100) % 10) * 256 + ((c / 10) % 10) * 16 + (c % 10));
    bl = {c < 1000, c < 100, c < 10, 1'b0};
    return {o, bl, b};
  endfunction

  // Scoreboard: each done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      logic [20:0] e;
      done_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_done: got %h, no result expected", {ovf, blank, bcd});
      end else begin
        e = exp_q.pop_front();
        if ({ovf, blank, bcd} !== e)
          $display("FAIL sb_result: got ovf/blank/bcd=%h, expected %h", {ovf, blank, bcd}, e);
        else
          n_pass++;
      end
    end
  end

  // Driver: present a new value (optionally with refresh) at a negedge.
  task automatic drive(input logic [15:0] v, input logic r);
    bin     = v;
    refresh = r;
    exp_q.push_back(model(v));
  endtask

  task automatic test_reset;
    int done_seen;
    int busy_seen;
    rst = 1'b1; bin = 16'd0; refresh = 1'b0;
    @(negedge clk);
    n_checks++; if (bcd !== 16'h0000) $display("FAIL rst_bcd: got %h, expected 0000", bcd); else n_pass++;
    n_checks++; if (blank !== 4'b1110) $display("FAIL rst_blank: got %b, expected 1110", blank); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b, expected 0", ovf); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b, expected 0", done); else n_pass++;
    rst = 1'b0;
    done_seen = 0; busy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    n_checks++; if (done_seen != 0) $display("FAIL idle_done: got %0d pulses, expected 0", done_seen); else n_pass++;
    n_checks++; if (busy_seen != 0) $display("FAIL idle_busy: got %0d busy cycles, expected 0", busy_seen); else n_pass++;
    n_checks++; if (bcd !== 16'h0000) $display("FAIL idle_bcd: got %h, expected 0000", bcd); else n_pass++;
  endtask

  task automatic test_latency;
    int first;
    int pulses;
    bit held_bad;
    bit busy1;
    logic [15:0] bcd_at;
    @(negedge clk);
    drive(16'd1234, 1'b0);
    first = 0; pulses = 0; held_bad = 0; busy1 = 0; bcd_at = 16'hxxxx;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (done) begin
        pulses++;
        if (first == 0) begin first = k; bcd_at = bcd; end
      end else if (first == 0 && bcd !== 16'h0000) begin
        held_bad = 1;
      end
    end
    n_checks++; if (busy1 !== 1'b1) $display("FAIL lat_busy: got %b one cycle after trigger, expected 1", busy1); else n_pass++;
    n_checks++; if (first != 18) $display("FAIL lat_done_cycle: got %0d, expected 18", first); else n_pass++;
    n_checks++; if (held_bad) $display("FAIL lat_bcd_hold: got changing bcd before done, expected 0000 held"); else n_pass++;
    n_checks++; if (pulses != 1) $display("FAIL lat_pulses: got %0d, expected 1", pulses); else n_pass++;
    n_checks++; if (bcd_at !== 16'h1234) $display("FAIL lat_bcd: got %h, expected 1234", bcd_at); else n_pass++;
    n_checks++; if (blank !== 4'b0000) $display("FAIL lat_blank: got %b, expected 0000", blank); else n_pass++;
  endtask

  task automatic test_values;
    logic [15:0] vals[6];
    int lat;
    vals = '{16'd7, 16'd40, 16'd9999, 16'd10000, 16'hFFFF, 16'd5};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(vals[i], 1'b0);
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
        @(negedge clk);
        if (done) lat = k;
      end
      n_checks++;
      if (lat != 18) $display("FAIL values_latency[%0d]: got %0d, expected 18", vals[i], lat); else n_pass++;
    end
    n_checks++; if (ovf !== 1'b0 || bcd !== 16'h0005) $display("FAIL values_ovf_clear: got ovf=%b bcd=%h, expected 0/0005", ovf, bcd); else n_pass++;
  endtask

  task automatic test_back_to_back_random;
    logic [15:0] v;
    logic        r;
    int          lat;
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) v = 16'($urandom_range(10000, 65535));
      else v = 16'($urandom_range(0, 9999));
      r = 1'($urandom_range(0, 1));
      if (v == bin) r = 1'b1;
      drive(v, r);
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
        @(negedge clk);
        if (k == 1) refresh = 1'b0;
        if (done) lat = k;
      end
      n_checks++;
      if (lat != 18) $display("FAIL b2b_latency[%0d]: got %0d, expected 18", i, lat); else n_pass++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mid_change;
    int base;
    @(negedge clk);
    base = done_cnt;
    drive(16'd12, 1'b1);
    @(negedge clk); refresh = 1'b0;
    repeat (4) @(negedge clk);
    bin = 16'd345;
    exp_q.push_back(model(16'd345));
    repeat (60) @(negedge clk);
    n_checks++; if (done_cnt - base != 2) $display("FAIL mid_two_conv: got %0d dones, expected 2", done_cnt - base); else n_pass++;
    @(negedge clk);
    base = done_cnt;
    drive(16'd12, 1'b0);
    repeat (3) @(negedge clk); bin = 16'd99;
    repeat (3) @(negedge clk); bin = 16'd12;
    repeat (60) @(negedge clk);
    n_checks++; if (done_cnt - base != 1) $display("FAIL mid_revert: got %0d dones, expected 1", done_cnt - base); else n_pass++;
  endtask

  task automatic test_refresh_reset;
    int base;
    bit busy_pre;
    @(negedge clk);
    drive(16'd808, 1'b0);
    repeat (30) @(negedge clk);
    base = done_cnt;
    drive(16'd808, 1'b1);
    @(negedge clk); refresh = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++; if (done_cnt - base != 1) $display("FAIL refresh_once: got %0d dones, expected 1", done_cnt - base); else n_pass++;
    n_checks++; if (bcd !== 16'h0808) $display("FAIL refresh_bcd: got %h, expected 0808", bcd); else n_pass++;
    // Abort a 4321 conversion with reset just before edge E8.
    @(negedge clk);
    bin = 16'd4321;
    repeat (7) @(negedge clk);
    busy_pre = busy;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (busy_pre !== 1'b1) $display("FAIL abort_busy_pre: got %b, expected 1", busy_pre); else n_pass++;
    n_checks++; if (bcd !== 16'h0000) $display("FAIL abort_bcd: got %h, expected 0000", bcd); else n_pass++;
    n_checks++; if (blank !== 4'b1110) $display("FAIL abort_blank: got %b, expected 1110", blank); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b, expected 0", busy); else n_pass++;
    n_checks++; if (ovf !== 1'b0 || done !== 1'b0) $display("FAIL abort_ovf_done: got %b/%b, expected 0/0", ovf, done); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = done_cnt;
    exp_q.push_back(model(16'd4321));
    repeat (40) @(negedge clk);
    n_checks++; if (done_cnt - base != 1) $display("FAIL post_rst_conv: got %0d dones, expected 1", done_cnt - base); else n_pass++;
    n_checks++; if (bcd !== 16'h4321) $display("FAIL post_rst_bcd: got %h, expected 4321", bcd); else n_pass++;
  endtask

  // Test sequence and final report
  initial begin
    rst = 1'b1; bin = 16'd0; refresh = 1'b0;
    test_reset();
    test_latency();
    test_values();
    test_back_to_back_random();
    test_mid_change();
    test_refresh_reset();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL queue_drained: got %0d outstanding, expected 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
